// File: rtl/sw_handshake_conditioner_if.sv
// Handshake/index bundle between the raw switch lines and the cpu-facing outputs.
// master drives the raw switches and observes the outputs; slave is the conditioner.
interface sw_handshake_conditioner_if #(
  parameter int WIDTH = 8
);
  logic             handshake_raw;
  logic [WIDTH-1:0] index_raw;
  logic             handshake;
  logic             hs_pulse;
  logic [WIDTH-1:0] index_q;
  logic [7:0]       cap_count;

  modport master (
    output handshake_raw, index_raw,
    input  handshake, hs_pulse, index_q, cap_count
  );

  modport slave (
    input  handshake_raw, index_raw,
    output handshake, hs_pulse, index_q, cap_count
  );
endinterface

// File: rtl/sw_handshake_conditioner.sv
// Slide-switch handshake conditioner: synchronizes and debounces the handshake,
// synchronizes the index, and captures the index on each debounced rising handshake.
//
//   state | meaning
//   IDLE  | handshake low, waiting for a debounced high level
//   HOLD  | handshake high, index_q frozen until the level drops
module sw_handshake_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WIDTH           = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  sw_handshake_conditioner_if.slave   bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [SYNC_STAGES-1:0] hs_sync_q, hs_sync_d;
  logic [WIDTH-1:0]       idx_sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]       idx_sync_d [SYNC_STAGES];
  logic                   hs_sync;
  logic [WIDTH-1:0]       index_sync;

  logic                   hs_stable_q, hs_stable_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  state_t                 state_q, state_d;
  logic                   pulse_q, pulse_d;
  logic [WIDTH-1:0]       idx_cap_q, idx_cap_d;
  logic [7:0]             cap_q, cap_d;

  assign hs_sync    = hs_sync_q[SYNC_STAGES-1];
  assign index_sync = idx_sync_q[SYNC_STAGES-1];

  always_comb begin
    hs_sync_d     = {hs_sync_q[SYNC_STAGES-2:0], bus.handshake_raw};
    idx_sync_d[0] = bus.index_raw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      idx_sync_d[i] = idx_sync_q[i-1];
    end
  end

  // Any sample matching the stable level restarts the count.
  always_comb begin
    hs_stable_d = hs_stable_q;
    cnt_d       = cnt_q;
    if (hs_sync == hs_stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      hs_stable_d = hs_sync;
      cnt_d       = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    pulse_d   = 1'b0;
    idx_cap_d = idx_cap_q;
    cap_d     = cap_q;
    case (state_q)
      IDLE: begin
        if (hs_stable_q) begin
          state_d   = HOLD;
          pulse_d   = 1'b1;
          idx_cap_d = index_sync;
          cap_d     = cap_q + 8'd1;
        end
      end
      HOLD: begin
        if (!hs_stable_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_sync_q   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) idx_sync_q[i] <= '0;
      hs_stable_q <= 1'b0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      pulse_q     <= 1'b0;
      idx_cap_q   <= '0;
      cap_q       <= '0;
    end else begin
      hs_sync_q   <= hs_sync_d;
      for (int i = 0; i < SYNC_STAGES; i++) idx_sync_q[i] <= idx_sync_d[i];
      hs_stable_q <= hs_stable_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      pulse_q     <= pulse_d;
      idx_cap_q   <= idx_cap_d;
      cap_q       <= cap_d;
    end
  end

  assign bus.handshake = (state_q == HOLD);
  assign bus.hs_pulse  = pulse_q;
  assign bus.index_q   = idx_cap_q;
  assign bus.cap_count = cap_q;
endmodule

// File: tb/tb_sw_handshake_conditioner.sv
// Bench for sw_handshake_conditioner: directed scenarios plus random switch activity,
// checked against a sample-history reference model.
module tb_sw_handshake_conditioner;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  sw_handshake_conditioner_if #(.WIDTH(W)) bus ();

  sw_handshake_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .WIDTH(W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: history of raw samples, one entry per clock edge (index 0 = newest).
  // The debouncer sees the sample taken SYNC edges earlier; the level flips once DB
  // consecutive seen samples all differ from it; the cpu-side outputs follow one edge later.
  logic         h_hist [0:15];
  logic [W-1:0] i_hist [0:15];
  logic         m_stable, m_hs, m_pulse;
  logic [W-1:0] m_idx;
  logic [7:0]   m_cap;

  always @(posedge clk) begin
    bit all_diff;
    for (int k = 15; k > 0; k--) begin
      h_hist[k] = h_hist[k-1];
      i_hist[k] = i_hist[k-1];
    end
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        h_hist[k] = 1'b0;
        i_hist[k] = '0;
      end
      m_stable = 1'b0; m_hs = 1'b0; m_pulse = 1'b0; m_idx = '0; m_cap = '0;
    end else begin
      h_hist[0] = bus.handshake_raw;
      i_hist[0] = bus.index_raw;
      m_pulse = m_stable && !m_hs;
      if (m_pulse) begin
        m_idx = i_hist[SYNC];
        m_cap = m_cap + 8'd1;
      end
      m_hs = m_stable;
      all_diff = 1'b1;
      for (int k = 0; k < DB; k++) if (h_hist[SYNC+k] == m_stable) all_diff = 1'b0;
      if (all_diff) m_stable = !m_stable;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    bus.handshake_raw = 1'b1;
    bus.index_raw = 8'hA5;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (bus.handshake !== 1'b0 || bus.hs_pulse !== 1'b0 || bus.index_q !== 8'h00 || bus.cap_count !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_state: hs=%b pulse=%b idx=%h cap=%0d, required all zero",
                 bus.handshake, bus.hs_pulse, bus.index_q, bus.cap_count);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.handshake !== (i >= 6) || bus.hs_pulse !== (i == 6)) begin
        n_fail++;
        $display("FAIL reset_release_latency edge %0d: hs=%b pulse=%b, required hs=%b pulse=%b",
                 i, bus.handshake, bus.hs_pulse, (i >= 6), (i == 6));
      end
    end
    n_checks++;
    if (bus.index_q !== 8'hA5 || bus.cap_count !== 8'd1) begin
      n_fail++;
      $display("FAIL reset_release_capture: idx=%h cap=%0d, required idx=a5 cap=1", bus.index_q, bus.cap_count);
    end
  endtask

  task automatic test_capture();
    bus.handshake_raw = 1'b0;
    bus.index_raw = 8'h3C;
    repeat (12) @(negedge clk);
    n_checks++;
    if (bus.handshake !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_idle: hs=%b, required 0", bus.handshake);
    end
    bus.handshake_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.handshake !== (i >= 6) || bus.hs_pulse !== (i == 6)) begin
        n_fail++;
        $display("FAIL capture_rise edge %0d: hs=%b pulse=%b, required hs=%b pulse=%b",
                 i, bus.handshake, bus.hs_pulse, (i >= 6), (i == 6));
      end
    end
    n_checks++;
    if (bus.index_q !== 8'h3C || bus.index_q !== m_idx || bus.cap_count !== m_cap) begin
      n_fail++;
      $display("FAIL capture_value: idx=%h cap=%0d, required idx=3c cap=%0d", bus.index_q, bus.cap_count, m_cap);
    end
    bus.index_raw = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.index_q !== 8'h3C || bus.handshake !== 1'b1) begin
        n_fail++;
        $display("FAIL capture_freeze: idx=%h hs=%b, required idx=3c hs=1", bus.index_q, bus.handshake);
      end
    end
    bus.handshake_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.handshake !== (i < 6) || bus.hs_pulse !== 1'b0 || bus.index_q !== 8'h3C) begin
        n_fail++;
        $display("FAIL capture_fall edge %0d: hs=%b pulse=%b idx=%h, required hs=%b pulse=0 idx=3c",
                 i, bus.handshake, bus.hs_pulse, bus.index_q, (i < 6));
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] cap0;
    cap0 = m_cap;
    for (int i = 0; i < 15; i++) begin
      bus.handshake_raw = (i < 3);
      @(negedge clk);
      n_checks++;
      if (bus.handshake !== 1'b0 || bus.hs_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_reject edge %0d: hs=%b pulse=%b, required 0 0", i, bus.handshake, bus.hs_pulse);
      end
    end
    n_checks++;
    if (bus.cap_count !== cap0) begin
      n_fail++;
      $display("FAIL glitch_cap: cap=%0d, required %0d", bus.cap_count, cap0);
    end
  endtask

  task automatic test_bounce();
    logic [8:0] pat;
    int pulses, first;
    pat = 9'b111101101;  // bit j drives edge j: 1,0,1,1,0,1,1,1,1
    pulses = 0;
    first = -1;
    for (int j = 0; j < 20; j++) begin
      bus.handshake_raw = (j < 9) ? pat[j] : 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.hs_pulse !== m_pulse || bus.handshake !== m_hs) begin
        n_fail++;
        $display("FAIL bounce_model edge %0d: hs=%b pulse=%b, required hs=%b pulse=%b",
                 j, bus.handshake, bus.hs_pulse, m_hs, m_pulse);
      end
      if (bus.hs_pulse === 1'b1) begin
        pulses++;
        if (first < 0) first = j;
      end
    end
    n_checks++;
    if (pulses != 1 || first != 11) begin
      n_fail++;
      $display("FAIL bounce_pulse: pulses=%0d at edge %0d, required 1 at edge 11", pulses, first);
    end
    bus.handshake_raw = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_hold();
    bus.index_raw = 8'h3C;
    bus.handshake_raw = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (bus.handshake !== 1'b1 || bus.index_q !== 8'h3C) begin
      n_fail++;
      $display("FAIL midhold_setup: hs=%b idx=%h, required hs=1 idx=3c", bus.handshake, bus.index_q);
    end
    bus.index_raw = 8'h81;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.handshake !== 1'b0 || bus.hs_pulse !== 1'b0 || bus.index_q !== 8'h00 || bus.cap_count !== 8'h00) begin
      n_fail++;
      $display("FAIL midhold_clear: hs=%b pulse=%b idx=%h cap=%0d, required all zero",
               bus.handshake, bus.hs_pulse, bus.index_q, bus.cap_count);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.handshake !== (i >= 6) || bus.hs_pulse !== (i == 6)) begin
        n_fail++;
        $display("FAIL midhold_recapture edge %0d: hs=%b pulse=%b, required hs=%b pulse=%b",
                 i, bus.handshake, bus.hs_pulse, (i >= 6), (i == 6));
      end
    end
    n_checks++;
    if (bus.index_q !== 8'h81 || bus.cap_count !== 8'd1) begin
      n_fail++;
      $display("FAIL midhold_value: idx=%h cap=%0d, required idx=81 cap=1", bus.index_q, bus.cap_count);
    end
  endtask

  task automatic test_random();
    int hold_left;
    hold_left = 0;
    for (int c = 0; c < 800; c++) begin
      if (hold_left == 0) begin
        bus.handshake_raw = $urandom_range(0, 1);
        hold_left = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 5);
      end
      hold_left--;
      if ($urandom_range(0, 7) == 0) bus.index_raw = 8'($urandom);
      @(negedge clk);
      n_checks++;
      if (bus.handshake !== m_hs || bus.hs_pulse !== m_pulse || bus.index_q !== m_idx || bus.cap_count !== m_cap) begin
        n_fail++;
        $display("FAIL random cycle %0d: hs=%b pulse=%b idx=%h cap=%0d, required hs=%b pulse=%b idx=%h cap=%0d",
                 c, bus.handshake, bus.hs_pulse, bus.index_q, bus.cap_count, m_hs, m_pulse, m_idx, m_cap);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] want;
    bus.handshake_raw = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      bus.index_raw = 8'(k);
      bus.handshake_raw = 1'b1;
      repeat (8) @(negedge clk);
      want = 8'(k);
      n_checks++;
      if (bus.cap_count !== want || bus.handshake !== 1'b1 || bus.index_q !== want) begin
        n_fail++;
        $display("FAIL wrap press %0d: cap=%0d hs=%b idx=%h, required cap=%0d hs=1 idx=%h",
                 k, bus.cap_count, bus.handshake, bus.index_q, want, want);
      end
      bus.handshake_raw = 1'b0;
      repeat (8) @(negedge clk);
    end
    n_checks++;
    if (bus.cap_count !== 8'd0 || bus.handshake !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_final: cap=%0d hs=%b, required cap=0 hs=0", bus.cap_count, bus.handshake);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.handshake_raw = 1'b0;
    bus.index_raw = '0;
    test_reset();
    test_capture();
    test_glitch();
    test_bounce();
    test_reset_mid_hold();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sw_handshake_conditioner.md
Name: sw_handshake_conditioner

Overview:
- Input conditioning stage that sits directly upstream of the cpu, on the slow clock domain.
- Takes the raw slide-switch handshake and index lines (SW[8], SW[7:0]) and synchronizes them into the clock domain.
- Debounces the handshake and runs a capture FSM.
- Presents to the cpu a clean handshake level, a one-cycle capture pulse, and an index value that is frozen for the whole time handshake is high.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on every raw input bit (min 2).
- DEBOUNCE_CYCLES, 4, consecutive synchronized samples that must differ from the current stable level before the level is accepted (min 1).
- WIDTH, 8, index width.

Ports:
- clk  input  1  slow system clock (the divided clock that also drives the cpu).
- reset  input  1  synchronous, active-high reset.
- handshake_raw  input  1  asynchronous raw handshake switch.
- index_raw  input  WIDTH  asynchronous raw index switches.
- handshake  output  1  conditioned handshake level; high iff FSM is in HOLD.
- hs_pulse  output  1  one-cycle pulse in the first cycle of HOLD.
- index_q  output  WIDTH  index captured on entry to HOLD; held until the next capture.
- cap_count  output  8  number of captures since reset, wraps 255->0.

Behaviour:
- Reset: a synchronous, active-high reset clears every register at the next clk edge.
  - Cleared: synchronizer flops, hs_stable, debounce counter, state=IDLE, handshake=0, hs_pulse=0, index_q=0, cap_count=0.
  - Reset has priority over all other activity.
- Synchronizer: SYNC_STAGES-deep flop chain per bit for handshake_raw and every index_raw bit. Outputs are hs_sync and index_sync.
- Debounce of hs_sync against the internal register hs_stable:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If hs_sync == hs_stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: hs_stable <= hs_sync and counter <= 0.
  - Else: counter <= counter+1.
  - Any sample equal to hs_stable restarts the count, so glitches shorter than DEBOUNCE_CYCLES synced samples never reach hs_stable.
- FSM, two states, IDLE and HOLD:
  - IDLE, hs_stable==1: next state HOLD; index_q <= index_sync; hs_pulse <= 1; cap_count <= cap_count+1.
  - IDLE, hs_stable==0: stay in IDLE; hs_pulse <= 0.
  - HOLD, hs_stable==0: next state IDLE.
  - HOLD, hs_stable==1: stay in HOLD.
  - In HOLD, hs_pulse <= 0; index_q and cap_count are unchanged.
- Outputs are all registered. handshake = (state==HOLD).
- Latency: the raw level changes and is first sampled at edge E.
  - hs_stable updates at edge E+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - handshake, hs_pulse and index_q update at edge E+SYNC_STAGES+DEBOUNCE_CYCLES, i.e. 6 cycles with defaults.
  - The falling edge has the same latency; hs_pulse does not assert on fall.
- Index bits are synchronized but not debounced. The protocol requires the operator to set the index before raising handshake.
- index_q ignores all index_raw changes while in HOLD and while in IDLE. It changes only on the IDLE->HOLD transition.
- Reset mid-HOLD: outputs return to 0 at the reset edge. If handshake_raw is still high after reset deasserts, a fresh capture occurs after the full latency.
  - That capture gives a new hs_pulse, the index as sampled then, and cap_count=1.
- Raw handshake toggling faster than the debounce window: no state change and no pulse.
- cap_count wraps 255->0 without saturating.

Test Plan:
- Reset: assert reset 2 cycles with handshake_raw=1 and index_raw=8'hA5 -> during reset handshake=0, hs_pulse=0, index_q=0, cap_count=0. After release (defaults), handshake rises and hs_pulse=1 for exactly one cycle on edge 6 after the first sampling edge; index_q=8'hA5; cap_count=1.
- Normal capture then release: index_raw=8'h3C, then handshake_raw 0->1 -> handshake=1 and index_q=8'h3C 6 edges later. Change index_raw to 8'hFF while high -> index_q stays 8'h3C. Drop handshake_raw -> handshake=0 6 edges later, no pulse, index_q stays 8'h3C.
- Glitch rejection: handshake_raw high for 3 cycles then low (DEBOUNCE_CYCLES=4) -> handshake stays 0, hs_pulse never asserts, cap_count unchanged.
- Bounce on press: handshake_raw pattern 1,0,1,1,0,1,1,1,1 -> exactly one hs_pulse, asserted 4 stable samples after the final continuous run of 1s begins (+ sync latency).
- Reset mid-HOLD: in HOLD with index_q=8'h3C, pulse reset for 1 cycle with handshake_raw still 1 and index_raw=8'h81 -> outputs clear, then recapture with index_q=8'h81, cap_count=1, one hs_pulse.
- Counter wrap: perform 256 press/release cycles -> cap_count reads 255 after the 255th capture and 0 after the 256th.
